multicycle_control_unit: RTL

Multi-cycle control FSM that replaces the single-cycle combinational decoder in the Antares-R2 datapath. Each instruction steps through fetch, decode, execute, memory, write-back or multiply/divide-wait states, with handshakes to instruction fetch and data memory. Multiply and divide latencies are configurable, and illegal opcodes are trapped. It issues the same microcommands as before, plus sequencing, link, HI/LO and trap signals.

---
 rtl/multicycle_control_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the Antares-R2 datapath: fetch/decode/exec/mem/wb sequencing with trap.
// Define CTRL_MULDIV_EN to build MUL/DIV/MFHI support (MULDIV state + latency counter).
module multicycle_control_unit #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic [1:0] branch,
  output logic       jump,
  output logic       link,
  output logic       regDst,
  output logic       aluSrc,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       regWrite,
  output logic       hiToReg,
  output logic       hiLoWrite,
  output logic       muldiv_start,
  output logic       muldiv_op,
  output logic       busy,
  output logic       illegal,
  output logic [2:0] state
);

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_cfg
    $error("multicycle_control_unit: MUL_CYCLES and DIV_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    MULDIV = 3'd5,
    TRAP   = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;

  logic is_rtype, is_j, is_jal, is_beq, is_bne, is_imm, is_load, is_store, base_legal;
  assign is_rtype   = (op_q == 6'b000000);
  assign is_j       = (op_q == 6'b000010);
  assign is_jal     = (op_q == 6'b000011);
  assign is_beq     = (op_q == 6'b000100);
  assign is_bne     = (op_q == 6'b000101);
  assign is_imm     = (op_q[5:3] == 3'b001);
  assign is_load    = (op_q[5:3] == 3'b100);
  assign is_store   = (op_q[5:3] == 3'b101);
  assign base_legal = is_rtype | is_j | is_jal | is_beq | is_bne | is_imm | is_load | is_store;

`ifdef CTRL_MULDIV_EN
  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic          is_mfhi, is_div, is_mul;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  assign is_mfhi = (op_q == 6'b010000);
  assign is_div  = (op_q == 6'b011010);
  assign is_mul  = (op_q == 6'b011100);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
`ifdef CTRL_MULDIV_EN
      cnt_q   <= '0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
`ifdef CTRL_MULDIV_EN
      cnt_q   <= cnt_d;
      first_q <= first_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
`ifdef CTRL_MULDIV_EN
    cnt_d        = cnt_q;
    first_d      = 1'b0;
`endif
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    branch       = 2'b00;
    jump         = 1'b0;
    link         = 1'b0;
    regDst       = 1'b0;
    aluSrc       = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memToReg     = 1'b0;
    regWrite     = 1'b0;
    hiToReg      = 1'b0;
    hiLoWrite    = 1'b0;
    muldiv_start = 1'b0;
    muldiv_op    = 1'b0;
    illegal      = 1'b0;
    busy         = (state_q != FETCH);
    state        = state_q;

    case (state_q)
      FETCH: begin
        pc_write = instr_valid;
        ir_write = instr_valid;
        if (instr_valid) begin
          op_d    = opcode;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (base_legal) state_d = EXEC;
`ifdef CTRL_MULDIV_EN
        else if (is_mul || is_div) begin
          state_d = MULDIV;
          cnt_d   = is_div ? DIV_LOAD : MUL_LOAD;
          first_d = 1'b1;
        end
        else if (is_mfhi) state_d = WB;
`endif
        else state_d = TRAP;
      end
      EXEC: begin
        state_d = FETCH;
        if (is_rtype) begin
          regDst  = 1'b1;
          state_d = WB;
        end else if (is_imm) begin
          aluSrc  = 1'b1;
          state_d = WB;
        end else if (is_load || is_store) begin
          aluSrc  = 1'b1;
          state_d = MEM;
        end else if (is_beq) begin
          branch = 2'b01;
        end else if (is_bne) begin
          branch = 2'b10;
        end else if (is_j || is_jal) begin
          jump     = 1'b1;
          pc_write = 1'b1;
          link     = is_jal;
          regWrite = is_jal;
        end
      end
      MEM: begin
        memRead  = is_load;
        memWrite = is_store;
        if (mem_ready) state_d = is_load ? WB : FETCH;
      end
      WB: begin
        regWrite = 1'b1;
        memToReg = is_load;
`ifdef CTRL_MULDIV_EN
        hiToReg  = is_mfhi;
        regDst   = is_rtype | is_mfhi;
`else
        regDst   = is_rtype;
`endif
        state_d  = FETCH;
      end
`ifdef CTRL_MULDIV_EN
      MULDIV: begin
        muldiv_start = first_q;
        muldiv_op    = is_div;
        if (cnt_q == '0) begin
          hiLoWrite = 1'b1;
          state_d   = FETCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      TRAP: illegal = 1'b1;
      default: state_d = FETCH;
    endcase

    // Reset masks every output, including the Mealy fetch strobes.
    if (reset) begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      branch       = 2'b00;
      jump         = 1'b0;
      link         = 1'b0;
      regDst       = 1'b0;
      aluSrc       = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      memToReg     = 1'b0;
      regWrite     = 1'b0;
      hiToReg      = 1'b0;
      hiLoWrite    = 1'b0;
      muldiv_start = 1'b0;
      muldiv_op    = 1'b0;
      illegal      = 1'b0;
      busy         = 1'b0;
      state        = '0;
    end
  end

endmodule
